// File: rtl/cla_seq_add_ctrl.sv
// Sequential WIDTH-bit adder: one 4-bit carry-lookahead slice, one nibble per clock, LSB first.
// Optional subtract mode when CLA_SEQ_SUB_EN is defined (adds a `sub` input port).
module cla_seq_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  // state | meaning
  // IDLE  | waiting for operands, in_ready=1
  // RUN   | one nibble per clock through the CLA slice
  // DONE  | result held until out_ready
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic             r_carry, r_cout, r_ovf;
  logic [IW-1:0]    r_idx;

  logic [WIDTH-1:0] w_b_in;
  logic             w_cin_in;
  logic [3:0]       w_an, w_bn, w_g, w_p, w_s;
  logic [4:0]       w_c;
  logic             w_accept, w_last;

`ifdef CLA_SEQ_SUB_EN
  assign w_b_in   = sub ? ~b : b;
  assign w_cin_in = sub ? 1'b1 : cin;
`else
  assign w_b_in   = b;
  assign w_cin_in = cin;
`endif

  assign w_an = 4'(r_a >> {r_idx, 2'b00});
  assign w_bn = 4'(r_b >> {r_idx, 2'b00});
  assign w_g  = w_an & w_bn;
  assign w_p  = w_an ^ w_bn;

  assign w_c[0] = r_carry;
  assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_s    = w_p ^ w_c[3:0];

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_last   = (r_idx == IW'(N - 1));

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= w_b_in;
      r_carry <= w_cin_in;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_sum[{r_idx, 2'b00} +: 4] <= w_s;
      r_carry <= w_c[4];
      if (w_last) begin
        // carry into the MSB is c3 of the top slice
        r_cout <= w_c[4];
        r_ovf  <= w_c[3] ^ w_c[4];
        r_idx  <= '0;
      end else begin
        r_idx  <= r_idx + IW'(1);
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_cla_seq_add_ctrl.sv
// Directed testbench for cla_seq_add_ctrl (WIDTH=16); subtract tests when CLA_SEQ_SUB_EN is defined.
module tb_cla_seq_add_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        cin;
`ifdef CLA_SEQ_SUB_EN
  logic        sub;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  cla_seq_add_ctrl #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
`ifdef CLA_SEQ_SUB_EN
    .sub      (sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operation in IDLE, return cycles from accept edge to out_valid (-1 on timeout).
  task automatic apply_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                          output int lat);
    @(negedge clk);
    a = ta; b = tb_; cin = tc; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; cin = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b1; out_ready = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL reset_sum got %h want 0000", sum); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if ({cout, ovf} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {cout, ovf}); end
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_no_capture in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_add();
    int lat;
    apply_op(16'h1234, 16'h4321, 1'b0, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL add_latency got %0d want 4", lat); end
    checks++; if (sum !== 16'h5555) begin errors++; $display("FAIL add_sum got %h want 5555", sum); end
    checks++; if ({cout, ovf} !== 2'b00) begin errors++; $display("FAIL add_flags got %b want 00", {cout, ovf}); end
    release_out();
  endtask

  task automatic test_carry();
    int lat;
    apply_op(16'hFFFF, 16'h0001, 1'b0, lat);
    checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL chain_sum got %h want 0000", sum); end
    checks++; if ({cout, ovf} !== 2'b10) begin errors++; $display("FAIL chain_flags got %b want 10", {cout, ovf}); end
    release_out();
    apply_op(16'h7FFF, 16'h0001, 1'b0, lat);
    checks++; if (sum !== 16'h8000) begin errors++; $display("FAIL ovf_sum got %h want 8000", sum); end
    checks++; if ({cout, ovf} !== 2'b01) begin errors++; $display("FAIL ovf_flags got %b want 01", {cout, ovf}); end
    release_out();
    apply_op(16'h0000, 16'hFFFF, 1'b1, lat);
    checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL cin_sum got %h want 0000", sum); end
    checks++; if ({cout, ovf} !== 2'b10) begin errors++; $display("FAIL cin_flags got %b want 10", {cout, ovf}); end
    release_out();
  endtask

  task automatic test_hold();
    int lat;
    apply_op(16'hABCD, 16'h1111, 1'b0, lat);
    @(negedge clk);
    in_valid = 1'b1; a = 16'h0F0F; b = 16'h0F0F; cin = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || sum !== 16'hBCDE || cout !== 1'b0 || ovf !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d got v=%b sum=%h c=%b o=%b rdy=%b want v=1 sum=bcde c=0 o=0 rdy=0",
                 k, out_valid, sum, cout, ovf, in_ready);
      end
    end
    in_valid = 1'b0;
    release_out();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_release in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_release out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
    checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL midrst_sum got %h want 0000", sum); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    apply_op(16'h00FF, 16'h0001, 1'b1, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL midrst_latency got %0d want 4", lat); end
    checks++; if (sum !== 16'h0101) begin errors++; $display("FAIL midrst_sum2 got %h want 0101", sum); end
    release_out();
  endtask

  task automatic test_back_to_back();
    int lat;
    apply_op(16'h8000, 16'h8000, 1'b0, lat);
    checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL b2b1_sum got %h want 0000", sum); end
    checks++; if ({cout, ovf} !== 2'b11) begin errors++; $display("FAIL b2b1_flags got %b want 11", {cout, ovf}); end
    release_out();
    apply_op(16'h0F0F, 16'h00F1, 1'b0, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL b2b2_latency got %0d want 4", lat); end
    checks++; if (sum !== 16'h1000) begin errors++; $display("FAIL b2b2_sum got %h want 1000", sum); end
    checks++; if ({cout, ovf} !== 2'b00) begin errors++; $display("FAIL b2b2_flags got %b want 00", {cout, ovf}); end
    release_out();
  endtask

`ifdef CLA_SEQ_SUB_EN
  task automatic test_sub();
    int lat;
    sub = 1'b1;
    apply_op(16'h0005, 16'h0007, 1'b0, lat);
    checks++; if (sum !== 16'hFFFE) begin errors++; $display("FAIL sub1_sum got %h want fffe", sum); end
    checks++; if ({cout, ovf} !== 2'b00) begin errors++; $display("FAIL sub1_flags got %b want 00", {cout, ovf}); end
    release_out();
    apply_op(16'h8000, 16'h0001, 1'b0, lat);
    checks++; if (sum !== 16'h7FFF) begin errors++; $display("FAIL sub2_sum got %h want 7fff", sum); end
    checks++; if ({cout, ovf} !== 2'b11) begin errors++; $display("FAIL sub2_flags got %b want 11", {cout, ovf}); end
    release_out();
    sub = 1'b0;
    apply_op(16'h0005, 16'h0007, 1'b1, lat);
    checks++; if (sum !== 16'h000D) begin errors++; $display("FAIL sub0_sum got %h want 000d", sum); end
    release_out();
  endtask
`endif

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
`ifdef CLA_SEQ_SUB_EN
    sub = 1'b0;
`endif
    test_reset();
    test_add();
    test_carry();
    test_hold();
    test_reset_mid_run();
    test_back_to_back();
`ifdef CLA_SEQ_SUB_EN
    test_sub();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
